// File: rtl/writeback_unit.sv
// RV32I writeback stage: MEM/WB register, result select, sub-word load formatting,
// late-load stall handshake, misaligned-load flagging and retire counting.
module writeback_unit #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_rd_we,
  input  logic [1:0]       mem_wb_sel,
  input  logic [XLEN-1:0]  mem_alu_result,
  input  logic [XLEN-1:0]  mem_pc_plus4,
  input  logic [XLEN-1:0]  mem_csr_rdata,
  input  logic [2:0]       mem_funct3,
  input  logic             flush,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_rvalid,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             wb_misaligned,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b001, 3'b101:                 return off[0];
      3'b010, 3'b011, 3'b110, 3'b111: return off != 2'b00;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] word);
    logic [XLEN-1:0] shifted;
    logic [7:0]      b;
    logic [15:0]     h;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  logic             vld_p1;
  logic [RA_W-1:0]  rd_p1;
  logic             rd_we_p1;
  logic [1:0]       sel_p1;
  logic [XLEN-1:0]  alu_p1;
  logic [XLEN-1:0]  pc4_p1;
  logic [XLEN-1:0]  csr_p1;
  logic [2:0]       f3_p1;
  logic [CNT_W-1:0] retire_q;

  logic is_load;
  logic misaligned;
  logic wb_done;
  logic take;

  assign is_load    = sel_p1 == SEL_LOAD;
  assign misaligned = is_load && is_misaligned(f3_p1, alu_p1[1:0]);
  // Misaligned loads never touch memory, so they retire without waiting for data.
  assign wb_done    = vld_p1 && (!is_load || misaligned || dmem_rvalid);
  assign mem_ready  = !vld_p1 || wb_done;
  assign take       = mem_valid && mem_ready && !flush;

  // MEM -> WB register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      rd_p1    <= '0;
      rd_we_p1 <= 1'b0;
      sel_p1   <= '0;
      alu_p1   <= '0;
      pc4_p1   <= '0;
      csr_p1   <= '0;
      f3_p1    <= '0;
      retire_q <= '0;
    end else begin
      if (take) begin
        vld_p1   <= 1'b1;
        rd_p1    <= mem_rd;
        rd_we_p1 <= mem_rd_we;
        sel_p1   <= mem_wb_sel;
        alu_p1   <= mem_alu_result;
        pc4_p1   <= mem_pc_plus4;
        csr_p1   <= mem_csr_rdata;
        f3_p1    <= mem_funct3;
      end else if (wb_done) begin
        vld_p1 <= 1'b0;
      end
      if (wb_done) retire_q <= retire_q + 1'b1;
    end
  end

  // WB stage outputs are combinational from the register and dmem inputs
  always_comb begin
    rf_wdata = csr_p1;
    case (sel_p1)
      SEL_ALU:  rf_wdata = alu_p1;
      SEL_LOAD: rf_wdata = format_load(f3_p1, alu_p1[1:0], dmem_rdata);
      SEL_PC4:  rf_wdata = pc4_p1;
      default:  rf_wdata = csr_p1;
    endcase
  end

  assign rf_waddr      = rd_p1;
  assign rf_we         = wb_done && rd_we_p1 && (rd_p1 != '0) && !misaligned;
  assign wb_misaligned = wb_done && misaligned;
  assign retire_count  = retire_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a write scoreboard checked at negedge.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_rd = '0;
  logic        mem_rd_we = 1'b0;
  logic [1:0]  mem_wb_sel = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_pc_plus4 = 32'h0000_0104;
  logic [31:0] mem_csr_rdata = 32'hCAFE_BABE;
  logic [2:0]  mem_funct3 = '0;
  logic        flush = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_rvalid = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_misaligned;
  logic [63:0] retire_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        mis;
  } exp_t;
  exp_t q[$];

  logic [2:0]  lf3  [8] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b000, 3'b010, 3'b011, 3'b100};
  logic [1:0]  loff [8] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd3};
  logic [31:0] lexp [8] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_80FF, 32'h0000_00FF,
                            32'h0000_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h0000_0080};

  writeback_unit #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_wb_sel(mem_wb_sel),
    .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
    .mem_csr_rdata(mem_csr_rdata), .mem_funct3(mem_funct3), .flush(flush),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_misaligned(wb_misaligned), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [2:0] f3);
    mem_valid      = 1'b1;
    mem_rd         = rd;
    mem_rd_we      = 1'b1;
    mem_wb_sel     = sel;
    mem_alu_result = alu;
    mem_funct3     = f3;
  endtask

  task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d, input logic mis);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.mis = mis;
    q.push_back(e);
  endtask

  // Scoreboard: every observed write or misaligned flag must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rf_we || wb_misaligned)) begin
      checks++;
      assert (q.size() != 0) else begin
        failures++;
        $error("FAIL spurious_write got=addr%0d exp=none", rf_waddr);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wb_we", 64'(rf_we), 64'(e.we));
        chk("wb_addr", 64'(rf_waddr), 64'(e.addr));
        chk("wb_mis", 64'(wb_misaligned), 64'(e.mis));
        if (!e.mis) chk("wb_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  initial begin
    #12;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_mis", 64'(wb_misaligned), 64'd0);
    chk("rst_ready", 64'(mem_ready), 64'd1);
    chk("rst_retire", retire_count, 64'd0);
    tick();
    rst = 1'b0;

    // ALU op
    drive(5'd5, 2'b00, 32'h1234_5678, 3'b000);
    push(1'b1, 5'd5, 32'h1234_5678, 1'b0);
    tick();
    mem_valid = 1'b0;
    tick();
    chk("alu_retire", retire_count, 64'd1);

    // Back-to-back formatted loads with data already present, then PC+4 and CSR
    dmem_rdata  = 32'h80FF_0000;
    dmem_rvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(5'd3, 2'b01, 32'h0000_1000 | 32'(loff[i]), lf3[i]);
      push(1'b1, 5'd3, lexp[i], 1'b0);
      tick();
    end
    drive(5'd7, 2'b10, 32'h0000_DEAD, 3'b000);
    push(1'b1, 5'd7, 32'h0000_0104, 1'b0);
    tick();
    drive(5'd8, 2'b11, 32'h0000_BEEF, 3'b000);
    push(1'b1, 5'd8, 32'hCAFE_BABE, 1'b0);
    @(negedge clk);
    chk("b2b_ready", 64'(mem_ready), 64'd1);
    tick();
    mem_valid = 1'b0;
    dmem_rvalid = 1'b0;
    tick();
    chk("b2b_retire", retire_count, 64'd11);

    // Late load data with a queued ALU op and a flush while the load waits
    drive(5'd9, 2'b01, 32'h0000_2000, 3'b010);
    push(1'b1, 5'd9, 32'h1122_3344, 1'b0);
    tick();
    drive(5'd10, 2'b00, 32'h0000_000A, 3'b000);
    push(1'b1, 5'd10, 32'h0000_000A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      @(negedge clk);
      chk("stall_ready", 64'(mem_ready), 64'd0);
      tick();
    end
    flush = 1'b0;
    dmem_rdata  = 32'h1122_3344;
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("stall_release", 64'(mem_ready), 64'd1);
    tick();
    dmem_rvalid = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk("stall_retire", retire_count, 64'd13);

    // Misaligned loads retire without data; rd=x0 write suppressed
    drive(5'd12, 2'b01, 32'h0000_1002, 3'b010);
    push(1'b0, 5'd12, 32'h0, 1'b1);
    tick();
    drive(5'd15, 2'b01, 32'h0000_1001, 3'b001);
    push(1'b0, 5'd15, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis_ready", 64'(mem_ready), 64'd1);
    tick();
    drive(5'd0, 2'b00, 32'h0000_0055, 3'b000);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("rd0_we", 64'(rf_we), 64'd0);
    tick();
    chk("mis_retire", retire_count, 64'd16);

    // Flush with mem_valid: nothing captured
    drive(5'd13, 2'b00, 32'h0000_0077, 3'b000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    chk("flush_we", 64'(rf_we), 64'd0);
    tick();
    chk("flush_retire", retire_count, 64'd16);

    // Asynchronous reset while a load waits
    drive(5'd14, 2'b01, 32'h0000_3000, 3'b010);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", 64'(mem_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst_we", 64'(rf_we), 64'd0);
    chk("arst_ready", 64'(mem_ready), 64'd1);
    chk("arst_retire", retire_count, 64'd0);
    chk("arst_waddr", 64'(rf_waddr), 64'd0);
    chk("arst_wdata", 64'(rf_wdata), 64'd0);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    @(negedge clk);
    chk("post_rst_we", 64'(rf_we), 64'd0);
    tick();
    dmem_rvalid = 1'b0;
    drive(5'd6, 2'b00, 32'h0000_0066, 3'b000);
    push(1'b1, 5'd6, 32'h0000_0066, 1'b0);
    tick();
    mem_valid = 1'b0;
    tick();
    chk("post_rst_retire", retire_count, 64'd1);

    tick();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Parametrised RV32I writeback stage that replaces the plain ALU/memory result mux. It holds the MEM/WB pipeline register and selects among four result sources. It formats sub-word loads (sign/zero extension, byte-lane alignment), waits for late load data with a ready/valid stall, flags misaligned loads, and counts retired instructions. It sits between the MEM stage and the register file write port, and also drives the EX-stage forwarding path.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- RA_W, 5, register address width.
- CNT_W, 64, retire counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  writeback unit accepts the instruction on this edge.
- mem_rd  in  RA_W  destination register.
- mem_rd_we  in  1  instruction writes rd.
- mem_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 CSR read data.
- mem_alu_result  in  XLEN  ALU result; bits [1:0] are the load byte offset.
- mem_pc_plus4  in  XLEN  link value for JAL/JALR.
- mem_csr_rdata  in  XLEN  CSR read value.
- mem_funct3  in  3  load type.
- flush  in  1  kill the instruction presented this cycle.
- dmem_rdata  in  XLEN  data memory read word, aligned to the word address.
- dmem_rvalid  in  1  dmem_rdata is valid this cycle.
- rf_we  out  1  register file write enable; also the forwarding valid.
- rf_waddr  out  RA_W  register file write address.
- rf_wdata  out  XLEN  register file write data.
- wb_misaligned  out  1  misaligned load is retiring this cycle.
- retire_count  out  CNT_W  number of completed instructions.

## Operation
- Register fields: wb_valid, rd, rd_we, wb_sel, alu_result, pc_plus4, csr_rdata, funct3.
- Reset value of every register field is 0; retire_count resets to 0.
- is_load = wb_sel==01.
- misaligned = is_load and one of:
  - funct3 in {001,101} with alu_result[0]=1;
  - funct3 in {010,011,110,111} with alu_result[1:0]!=0.
- wb_done = wb_valid and (not is_load, or misaligned, or dmem_rvalid).
- Handshake:
  - mem_ready = !wb_valid or wb_done.
  - Transfer occurs when mem_valid and mem_ready.
  - On transfer without flush: all fields are loaded and wb_valid is set to 1.
  - When wb_done and there is no transfer: wb_valid is cleared to 0.
  - flush=1 blocks the load and clears wb_valid to 0 if wb_done; flush wins over transfer.
  - An instruction already held in the register is never flushed.
- Load formatting, with off = alu_result[1:0]:
  - byte = dmem_rdata[8*off +: 8]; half = dmem_rdata[16*off[1] +: 16].
  - 000 LB sign-extends byte.
  - 001 LH sign-extends half.
  - 100 LBU zero-extends byte.
  - 101 LHU zero-extends half.
  - 010, 011, 110 and 111 all return the full word (LW).
- rf_wdata by wb_sel: alu_result, formatted load, pc_plus4, or csr_rdata. rf_wdata is always driven, even when rf_we=0.
- rf_waddr = rd.
- rf_we = wb_done and rd_we and rd!=0 and !misaligned.
- wb_misaligned = wb_done and misaligned.
- retire_count increments by 1 on every cycle with wb_done, including rd=x0 and misaligned instructions. It wraps modulo 2^CNT_W.

## Timing
- Latency: an instruction transferred at edge N produces its rf_* outputs combinationally during cycle N+1 (one register stage).
- Non-load instructions complete in cycle N+1, and back-to-back transfers sustain one instruction per cycle.
- Loads complete in the first cycle at or after N+1 with dmem_rvalid=1.
  - mem_ready stays 0 while a load waits.
  - dmem_rvalid is ignored when no load is held.
- Misaligned loads complete in cycle N+1 without waiting for dmem_rvalid.
- rf_* and wb_misaligned are pure functions of the register and the dmem_* inputs; there is no extra output flop.
- Asynchronous reset mid-load drops the instruction immediately:
  - rf_we=0, mem_ready=1, retire_count=0.
  - A later dmem_rvalid has no effect.
- Values after reset: rf_we=0, rf_waddr=0, rf_wdata=0, wb_misaligned=0, mem_ready=1.

## Test plan
- ALU op: rd=5, sel=00, alu=0x1234_5678 -> next cycle rf_we=1, waddr=5, wdata=0x12345678; retire_count=1.
- LB at off=3 with dmem_rdata=0x80FF_0000 -> wdata=0xFFFFFF80. LHU at off=2 with the same word -> wdata=0x000080FF.
- Load with dmem_rvalid delayed 3 cycles, plus a queued ALU op -> mem_ready=0 for 3 cycles. The load writes in cycle 4 and the ALU op writes in cycle 5; no write is lost or duplicated.
- LW at addr 0x1002 -> wb_misaligned=1 for one cycle, rf_we=0, retire_count increments. Write to rd=0 -> rf_we=0, retire_count increments.
- flush asserted with mem_valid -> no capture and no write. A flush while a load is waiting leaves that load intact.
- rst asserted mid-stall -> all outputs return to reset values asynchronously; a following ALU op retires normally and retire_count reads 1.
